// File: rtl/voice_mixer_weighted_if.sv
// Bus interface for voice_mixer_weighted: per-voice samples and gains, master
// attenuation, input/output valid-ready handshakes and clip status.
interface voice_mixer_weighted_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VOICES = 8,
  parameter int GAIN_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] voice_in   [NUM_VOICES];
  logic        [GAIN_WIDTH-1:0] voice_gain [NUM_VOICES];
  logic        [3:0]            master_shift;
  logic                         data_in_valid;
  logic                         data_in_ready;
  logic signed [DATA_WIDTH-1:0] mixed_out;
  logic                         data_out_valid;
  logic                         data_out_ready;
  logic                         clip;
  logic                         clip_sticky;
  logic                         clip_clear;

  // Mixer side.
  modport slave (
    input  voice_in, voice_gain, master_shift, data_in_valid, data_out_ready, clip_clear,
    output data_in_ready, mixed_out, data_out_valid, clip, clip_sticky
  );

  // Voice bank / downstream side.
  modport master (
    output voice_in, voice_gain, master_shift, data_in_valid, data_out_ready, clip_clear,
    input  data_in_ready, mixed_out, data_out_valid, clip, clip_sticky
  );
endinterface

// File: rtl/voice_mixer_weighted.sv
// Weighted N-voice mixer: per-voice gain (stage M), full-precision pipelined
// adder tree (T1..Tk), master shift plus single output saturation (stage S).
// Whole pipeline stalls together on output back-pressure.
// Optional feature: define VOICE_MIXER_GAIN_RAMP_EN to slew each voice's gain
// toward its target by at most RAMP_STEP per accepted beat (fade-in from 0).
module voice_mixer_weighted #(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_VOICES = 8,
  parameter int          GAIN_WIDTH = 16,
  parameter int unsigned RAMP_STEP  = 64
) (
  input logic                   clk,
  input logic                   rst,
  voice_mixer_weighted_if.slave bus
);
  localparam int K      = $clog2(NUM_VOICES);
  localparam int N_PAD  = 1 << K;
  localparam int W_P    = DATA_WIDTH + 1;
  localparam int W_SUM  = DATA_WIDTH + 1 + K;
  localparam int W_FULL = DATA_WIDTH + GAIN_WIDTH + 1;

  localparam logic signed [DATA_WIDTH-1:0] MAX_S = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_S = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                         adv;
  logic                         accept;
  logic        [K:0]            valid_q;      // [0] = stage M, [l] = tree level l
  logic                         out_valid_q;
  logic signed [DATA_WIDTH-1:0] mixed_q;
  logic                         clip_q;
  logic                         sticky_q, sticky_d;
  logic        [GAIN_WIDTH-1:0] g_use [NUM_VOICES];

  // Every level is stored at the final tree width; level l only ever holds
  // values that fit DATA_WIDTH+1+l bits, so nothing can wrap.
  logic signed [W_SUM-1:0] tree_q [K+1][N_PAD];
  logic signed [W_SUM-1:0] tree_d [K+1][N_PAD];

  logic signed [W_SUM-1:0]      y;
  logic                         ovf;
  logic signed [DATA_WIDTH-1:0] sat_out;

  assign adv               = !out_valid_q || bus.data_out_ready;
  assign bus.data_in_ready = adv && !rst;
  assign accept            = bus.data_in_valid && bus.data_in_ready;

`ifdef VOICE_MIXER_GAIN_RAMP_EN
  localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);

  logic [GAIN_WIDTH-1:0] g_cur_q [NUM_VOICES];
  logic [GAIN_WIDTH-1:0] g_cur_d [NUM_VOICES];

  // Slew each current gain toward its target on accepted beats, never overshooting.
  always_comb begin
    logic [GAIN_WIDTH-1:0] diff;
    diff    = '0;
    g_cur_d = g_cur_q;
    if (accept) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (bus.voice_gain[i] > g_cur_q[i]) begin
          diff       = bus.voice_gain[i] - g_cur_q[i];
          g_cur_d[i] = g_cur_q[i] + ((diff > STEP) ? STEP : diff);
        end else begin
          diff       = g_cur_q[i] - bus.voice_gain[i];
          g_cur_d[i] = g_cur_q[i] - ((diff > STEP) ? STEP : diff);
        end
      end
    end
  end

  // Current-gain registers; reset to 0 gives a fade-in after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rst) g_cur_q[i] <= '0;
      else     g_cur_q[i] <= g_cur_d[i];
    end
  end

  // Stage M multiplies with the gain in effect before this beat's step.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) g_use[i] = g_cur_q[i];
  end
`else
  // Stage M multiplies with the target gain presented alongside the beat.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) g_use[i] = bus.voice_gain[i];
  end
`endif

  // Products for stage M and pairwise sums for every tree level.
  // NOTE: every variable gets a default before any conditional/loop write, so no latch is inferred.
  always_comb begin
    logic signed [W_FULL-1:0] prod;
    logic signed [W_P-1:0]    p_lane;
    prod   = '0;
    p_lane = '0;
    for (int l = 0; l <= K; l++) begin
      for (int j = 0; j < N_PAD; j++) tree_d[l][j] = '0;
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      prod         = $signed(bus.voice_in[i]) * $signed({1'b0, g_use[i]});
      p_lane       = W_P'(prod >>> (GAIN_WIDTH - 1));
      tree_d[0][i] = W_SUM'(p_lane);
    end
    for (int l = 1; l <= K; l++) begin
      for (int j = 0; j < (N_PAD >> l); j++) begin
        tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
      end
    end
  end

  // Stage S: master attenuation, then clamp to the signed output range.
  always_comb begin
    logic [W_SUM-DATA_WIDTH:0] hi;
    y       = tree_q[K][0] >>> bus.master_shift;
    hi      = y[W_SUM-1:DATA_WIDTH-1];
    ovf     = !((&hi) || !(|hi));
    sat_out = ovf ? (y[W_SUM-1] ? MIN_S : MAX_S) : y[DATA_WIDTH-1:0];
    sticky_d = (sticky_q && !bus.clip_clear) || (adv && valid_q[K] && ovf);
  end

  // Pipeline registers: everything advances together on adv; data loads only with valid.
  // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      mixed_q     <= '0;
      clip_q      <= 1'b0;
      sticky_q    <= 1'b0;
      // NOTE: the data stages are reset explicitly so a flushed pipeline holds zeros, not stale beats.
      for (int l = 0; l <= K; l++) begin
        for (int j = 0; j < N_PAD; j++) tree_q[l][j] <= '0;
      end
    end else begin
      sticky_q <= sticky_d;
      if (adv) begin
        valid_q[0]  <= accept;
        out_valid_q <= valid_q[K];
        if (accept) tree_q[0] <= tree_d[0];
        for (int l = 1; l <= K; l++) begin
          valid_q[l] <= valid_q[l-1];
          if (valid_q[l-1]) tree_q[l] <= tree_d[l];
        end
        if (valid_q[K]) begin
          mixed_q <= sat_out;
          clip_q  <= ovf;
        end
      end
    end
  end

  assign bus.mixed_out      = mixed_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.clip           = clip_q;
  assign bus.clip_sticky    = sticky_q;
endmodule
